pipe_skid_latch: RTL
====================

// Module: pipe_skid_latch
// PURPOSE
//  Parametrised inter-stage pipeline latch carrying {instr, instr_set, pc}.
//  Valid/ready handshake with a 2-entry skid buffer: downstream back-pressure
//  is absorbed without a combinational ready path, and flush inserts a bubble.
//  Drop-in between any two pipeline stages (IF..WB), e.g. RA->RO.
// PARAMETERS
//  INSTR_W     12          instruction word width
//  ISET_W      4           instruction-set tag width
//  PC_W        12          program-counter width
//  NOP_INSTR   {INSTR_W{0}} bubble instruction loaded on reset/flush
//  RESET_ISET  `ISET_BASE  instr-set tag loaded on reset/flush
// PORTS
//  clk            in   1        clock, all state on rising edge
//  rst_n          in   1        synchronous reset, active low
//  flush          in   1        synchronous flush, drops all held entries
//  in_valid       in   1        upstream entry valid
//  in_ready       out  1        latch can accept (registered)
//  instr_in       in   INSTR_W  upstream instruction
//  instr_set_in   in   ISET_W   upstream instruction-set tag
//  pc_in          in   PC_W     upstream PC
//  out_valid      out  1        output entry valid
//  out_ready      in   1        downstream accepts
//  instr_out      out  INSTR_W  instruction to next stage
//  instr_set_out  out  ISET_W   instr-set tag to next stage
//  pc_out         out  PC_W     PC to next stage
//  occupancy      out  2        entries held, 0..2
// BEHAVIOUR
//  - in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
//  - Storage: main reg (drives *_out) + skid reg. FSM EMPTY/ONE/TWO; out_valid
//    = (state!=EMPTY), in_ready = (state!=TWO), occupancy = 0/1/2; all decoded
//    from the state register only, no comb path from out_ready or in_valid.
//  - EMPTY: in_fire -> ONE, main<=in.
//  - ONE: in_fire&!out_fire -> TWO, skid<=in; !in_fire&out_fire -> EMPTY;
//    in_fire&out_fire -> ONE, main<=in; neither -> hold.
//  - TWO: out_fire -> ONE, main<=skid; else hold (in_ready=0, no in_fire).
//  - Latency: in_fire at edge N -> visible on *_out after edge N (1 cycle).
//    Throughput 1 entry/cycle while out_ready=1. Order strictly FIFO.
//  - Payload stable while out_valid & !out_ready. In EMPTY, main keeps its
//    last value (out_valid=0 qualifies it).
//  - Reset (rst_n=0 at edge): state EMPTY, in_ready=0 for that cycle then 1,
//    instr_out=NOP_INSTR, instr_set_out=RESET_ISET, pc_out=0, skid cleared
//    likewise, occupancy=0. Reset overrides flush and any handshake.
//  - flush=1 at edge: same register values as reset; in_fire of that cycle
//    is discarded; out_fire of that cycle still counts as consumed downstream.
//  - No width arithmetic; payload is copied bit-exact.
// STRUCTURE
//  - Shared iset.vh: ISET_* tags (RESET_ISET default) and a common NOP
//    encoding constant used by all stage latches.
//  - One natural sub-module: pipe_skid_reg (single payload reg with load
//    enable and bubble load), instanced twice for main and skid.
//  - FSM encoding local (2-bit state == occupancy).
// TESTING
//  1 Reset: rst_n=0 two cycles -> out_valid=0, occupancy=0, instr_out=NOP,
//    instr_set_out=ISET_BASE, pc_out=0; in_ready=1 first cycle after release.
//  2 Streaming: out_ready=1, send pc 0x010..0x01F back-to-back -> outputs
//    appear 1 cycle later, in order, no gaps, occupancy stays 1.
//  3 Back-pressure: out_ready=0, send A(pc 0x100),B(0x101),C(0x102) -> A,B
//    held, occupancy=2, in_ready=0, C stalls; raise out_ready -> A,B,C in order.
//  4 Flush in TWO: occupancy=2, flush=1 with in_valid=1 -> next cycle
//    out_valid=0, occupancy=0, instr_out=NOP, incoming entry lost.
//  5 Simultaneous in/out in ONE: in_fire & out_fire same edge -> occupancy
//    stays 1, new entry on outputs next cycle.
//  6 Reset mid-burst with occupancy=2 and flush=1 -> reset values, no entry
//    emitted; random stall/flush scoreboard run >=10k cycles, zero mismatches.

Source files
------------

// File: rtl/pipe_skid_latch_pkg.sv
// Shared definitions for the pipeline stage latches: instr-set tags, the common
// bubble encoding, and the occupancy-encoded latch state.
package pipe_skid_latch_pkg;

  localparam int INSTR_W_DEF = 12;
  localparam int ISET_W_DEF  = 4;
  localparam int PC_W_DEF    = 12;

  localparam logic [ISET_W_DEF-1:0]  ISET_BASE = 4'h0;
  localparam logic [ISET_W_DEF-1:0]  ISET_EXT  = 4'h1;
  localparam logic [ISET_W_DEF-1:0]  ISET_VEC  = 4'h2;
  localparam logic [INSTR_W_DEF-1:0] NOP_ENC   = 12'h000;

  // State value equals the number of held entries.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_e;

endpackage

// File: rtl/pipe_skid_latch_if.sv
// Handshake and payload bundle between an upstream stage, the latch, and the
// downstream stage.
interface pipe_skid_latch_if #(
  parameter int INSTR_W = 12,
  parameter int ISET_W  = 4,
  parameter int PC_W    = 12
);
  logic               in_valid;
  logic               in_ready;
  logic [INSTR_W-1:0] instr_in;
  logic [ISET_W-1:0]  instr_set_in;
  logic [PC_W-1:0]    pc_in;
  logic               out_valid;
  logic               out_ready;
  logic [INSTR_W-1:0] instr_out;
  logic [ISET_W-1:0]  instr_set_out;
  logic [PC_W-1:0]    pc_out;
  logic [1:0]         occupancy;

  modport slave (
    input  in_valid, instr_in, instr_set_in, pc_in, out_ready,
    output in_ready, out_valid, instr_out, instr_set_out, pc_out, occupancy
  );

  modport master (
    output in_valid, instr_in, instr_set_in, pc_in, out_ready,
    input  in_ready, out_valid, instr_out, instr_set_out, pc_out, occupancy
  );
endinterface

// File: rtl/pipe_skid_latch_reg.sv
// Single payload register with load enable; clear loads the bubble value and
// takes priority over load.
module pipe_skid_latch_reg #(
  parameter int             W      = 28,
  parameter logic [W-1:0]   BUBBLE = '0
) (
  input  logic         clk,
  input  logic         i_clear,
  input  logic         i_load,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);
  logic [W-1:0] r_q;

  always_ff @(posedge clk) begin
    if (i_clear)     r_q <= BUBBLE;
    else if (i_load) r_q <= i_d;
  end

  assign o_q = r_q;
endmodule

// File: rtl/pipe_skid_latch.sv
// Inter-stage pipeline latch {instr, instr_set, pc} with a 2-entry skid buffer.
// state    | meaning
// ST_EMPTY | nothing held, main keeps last value (out_valid=0)
// ST_ONE   | main holds the head entry
// ST_TWO   | main holds head, skid holds next; upstream stalled
module pipe_skid_latch
  import pipe_skid_latch_pkg::*;
#(
  parameter int                   INSTR_W    = INSTR_W_DEF,
  parameter int                   ISET_W     = ISET_W_DEF,
  parameter int                   PC_W       = PC_W_DEF,
  parameter logic [INSTR_W-1:0]   NOP_INSTR  = NOP_ENC,
  parameter logic [ISET_W-1:0]    RESET_ISET = ISET_BASE
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                flush,
  pipe_skid_latch_if.slave    bus
);
  localparam int           W      = INSTR_W + ISET_W + PC_W;
  localparam logic [W-1:0] BUBBLE = {NOP_INSTR, RESET_ISET, {PC_W{1'b0}}};

  state_e       r_state, w_state_n;
  logic         r_in_ready;
  logic         w_in_fire, w_out_fire, w_clear;
  logic         w_load_main, w_load_skid, w_main_from_skid;
  logic [W-1:0] w_in_data, w_main_d, w_main_q, w_skid_q;

  assign w_in_fire  = bus.in_valid & r_in_ready;
  assign w_out_fire = (r_state != ST_EMPTY) & bus.out_ready;
  assign w_clear    = ~rst_n | flush;
  assign w_in_data  = {bus.instr_in, bus.instr_set_in, bus.pc_in};
  assign w_main_d   = w_main_from_skid ? w_skid_q : w_in_data;

  always_comb begin
    w_state_n        = r_state;
    w_load_main      = 1'b0;
    w_load_skid      = 1'b0;
    w_main_from_skid = 1'b0;
    case (r_state)
      ST_EMPTY: begin
        if (w_in_fire) begin
          w_state_n   = ST_ONE;
          w_load_main = 1'b1;
        end
      end
      ST_ONE: begin
        if (w_in_fire && !w_out_fire) begin
          w_state_n   = ST_TWO;
          w_load_skid = 1'b1;
        end else if (!w_in_fire && w_out_fire) begin
          w_state_n   = ST_EMPTY;
        end else if (w_in_fire && w_out_fire) begin
          w_load_main = 1'b1;
        end
      end
      ST_TWO: begin
        if (w_out_fire) begin
          w_state_n        = ST_ONE;
          w_load_main      = 1'b1;
          w_main_from_skid = 1'b1;
        end
      end
      default: w_state_n = ST_EMPTY;
    endcase
  end

  // in_ready is held low for the cycle following a reset edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= ST_EMPTY;
      r_in_ready <= 1'b0;
    end else if (flush) begin
      r_state    <= ST_EMPTY;
      r_in_ready <= 1'b1;
    end else begin
      r_state    <= w_state_n;
      r_in_ready <= (w_state_n != ST_TWO);
    end
  end

  pipe_skid_latch_reg #(.W(W), .BUBBLE(BUBBLE)) u_main (
    .clk     (clk),
    .i_clear (w_clear),
    .i_load  (w_load_main),
    .i_d     (w_main_d),
    .o_q     (w_main_q)
  );

  pipe_skid_latch_reg #(.W(W), .BUBBLE(BUBBLE)) u_skid (
    .clk     (clk),
    .i_clear (w_clear),
    .i_load  (w_load_skid),
    .i_d     (w_in_data),
    .o_q     (w_skid_q)
  );

  assign bus.in_ready      = r_in_ready;
  assign bus.out_valid     = (r_state != ST_EMPTY);
  assign bus.occupancy     = r_state;
  assign bus.instr_out     = w_main_q[W-1 -: INSTR_W];
  assign bus.instr_set_out = w_main_q[PC_W +: ISET_W];
  assign bus.pc_out        = w_main_q[PC_W-1:0];
endmodule
